// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a small FIFO of fetched instruction words that
// presents the oldest word to the control unit split into four equal fields.
// The head is flushed on taken branches/jumps, and a sticky flag records any
// fetch dropped because the queue was full.
module instr_prefetch_queue #(
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    parameter int FW    = IW / 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] instr_data,
    input  logic          irwr,
    input  logic          ir_rd,
    input  logic          flush,
    output logic [FW-1:0] instr_f3,
    output logic [FW-1:0] instr_f2,
    output logic [FW-1:0] instr_f1,
    output logic [FW-1:0] instr_f0,
    output logic          ir_valid,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;
    logic [IW-1:0] head;

    // Status flags derive from the registered occupancy only
    always_comb begin
        ir_valid = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        count    = count_q;
        ovf      = ovf_q;
    end

    // Accept decisions; a pop frees a slot so a push into a full queue still lands
    always_comb begin
        pop_ok  = ir_rd & ir_valid & ~flush;
        push_ok = irwr & (~full | pop_ok) & ~flush;
    end

    // Next-state for pointers, occupancy and sticky overflow; flush wins over everything
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push_ok) wp_d = wp_q + PW'(1);
            if (pop_ok)  rp_d = rp_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            if (irwr && full && !pop_ok) ovf_d = 1'b1;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately not reset; outputs mask it while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= instr_data;
    end

    // Head word split into fields, zeroed when nothing is queued
    always_comb begin
        head     = ir_valid ? mem_q[rp_q] : '0;
        instr_f3 = head[IW-1:3*FW];
        instr_f2 = head[3*FW-1:2*FW];
        instr_f1 = head[2*FW-1:FW];
        instr_f0 = head[FW-1:0];
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (IW=16, DEPTH=4).
module tb_instr_prefetch_queue;

    localparam int IW = 16;
    localparam int DEPTH = 4;
    localparam int FW = IW / 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] instr_data;
    logic          irwr, ir_rd, flush;
    logic [FW-1:0] instr_f3, instr_f2, instr_f1, instr_f0;
    logic          ir_valid, full, ovf;
    logic [CW-1:0] count;

    int n_total = 0;
    int n_pass  = 0;
    logic [IW-1:0] model_q[$];
    logic [IW-1:0] w;

    instr_prefetch_queue #(
        .IW(IW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_data(instr_data),
        .irwr(irwr),
        .ir_rd(ir_rd),
        .flush(flush),
        .instr_f3(instr_f3),
        .instr_f2(instr_f2),
        .instr_f1(instr_f1),
        .instr_f0(instr_f0),
        .ir_valid(ir_valid),
        .full(full),
        .count(count),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] head();
        return {instr_f3, instr_f2, instr_f1, instr_f0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply strobes across one rising edge, then sample 1 time unit later
    task automatic cycle(input logic wr, input logic rd, input logic fl,
                         input logic [IW-1:0] data);
        irwr = wr; ir_rd = rd; flush = fl; instr_data = data;
        @(posedge clk);
        #1;
        irwr = 1'b0; ir_rd = 1'b0; flush = 1'b0; instr_data = '0;
    endtask

    task automatic fill_1_to_4();
        cycle(1'b1, 1'b0, 1'b0, 16'h1111);
        cycle(1'b1, 1'b0, 1'b0, 16'h2222);
        cycle(1'b1, 1'b0, 1'b0, 16'h3333);
        cycle(1'b1, 1'b0, 1'b0, 16'h4444);
    endtask

    initial begin
        rst_n = 1'b0; irwr = 1'b0; ir_rd = 1'b0; flush = 1'b0; instr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(ir_valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_head", 32'(head()), 0);
        rst_n = 1'b1;

        // Single push then pop
        cycle(1'b1, 1'b0, 1'b0, 16'hA5C3);
        check("single_valid", 32'(ir_valid), 1);
        check("single_f3", 32'(instr_f3), 32'hA);
        check("single_f2", 32'(instr_f2), 32'h5);
        check("single_f1", 32'(instr_f1), 32'hC);
        check("single_f0", 32'(instr_f0), 32'h3);
        check("single_count", 32'(count), 1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("single_pop_valid", 32'(ir_valid), 0);
        check("single_pop_head", 32'(head()), 0);

        // Fill and overflow
        fill_1_to_4();
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        check("fill_ovf_clear", 32'(ovf), 0);
        cycle(1'b1, 1'b0, 1'b0, 16'h5555);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_head", 32'(head()), 32'h1111);
        check("ovf_count", 32'(count), 4);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", 32'(head()), 32'(i * 16'h1111));
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        check("ovf_drain_empty", 32'(ir_valid), 0);
        check("ovf_sticky", 32'(ovf), 1);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("flush_clears_ovf", 32'(ovf), 0);

        // Full with simultaneous push and pop
        fill_1_to_4();
        cycle(1'b1, 1'b1, 1'b0, 16'h5555);
        check("fullpp_count", 32'(count), 4);
        check("fullpp_ovf", 32'(ovf), 0);
        for (int i = 2; i <= 5; i++) begin
            check("fullpp_drain", 32'(head()), 32'(i * 16'h1111));
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        check("fullpp_empty", 32'(count), 0);

        // Empty with simultaneous push and pop, then pop on empty
        cycle(1'b1, 1'b1, 1'b0, 16'h7777);
        check("emptypp_count", 32'(count), 1);
        check("emptypp_head", 32'(head()), 32'h7777);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("pop_empty_count", 32'(count), 0);
        check("pop_empty_valid", 32'(ir_valid), 0);
        check("pop_empty_ovf", 32'(ovf), 0);

        // Flush priority with three entries and ovf set
        fill_1_to_4();
        cycle(1'b1, 1'b0, 1'b0, 16'h5555);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("pre_flush_count", 32'(count), 3);
        check("pre_flush_ovf", 32'(ovf), 1);
        cycle(1'b1, 1'b1, 1'b1, 16'h9999);
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(ir_valid), 0);
        check("flush_ovf", 32'(ovf), 0);
        check("flush_head", 32'(head()), 0);
        cycle(1'b1, 1'b0, 1'b0, 16'h1234);
        check("post_flush_head", 32'(head()), 32'h1234);
        check("post_flush_count", 32'(count), 1);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Sustained push+pop across pointer wrap at occupancy 1, then 3
        w = 16'h0100;
        cycle(1'b1, 1'b0, 1'b0, w);
        model_q.push_back(w);
        for (int i = 1; i <= 10; i++) begin
            w = 16'h0100 + 16'(i);
            check("wrap1_head", 32'(head()), 32'(model_q[0]));
            cycle(1'b1, 1'b1, 1'b0, w);
            void'(model_q.pop_front());
            model_q.push_back(w);
            check("wrap1_count", 32'(count), 1);
        end
        for (int i = 0; i < 2; i++) begin
            w = 16'h0200 + 16'(i);
            cycle(1'b1, 1'b0, 1'b0, w);
            model_q.push_back(w);
        end
        for (int i = 0; i < 9; i++) begin
            w = 16'h0300 + 16'(i);
            check("wrap3_head", 32'(head()), 32'(model_q[0]));
            cycle(1'b1, 1'b1, 1'b0, w);
            void'(model_q.pop_front());
            model_q.push_back(w);
            check("wrap3_count", 32'(count), 3);
        end
        while (model_q.size() > 0) begin
            check("wrap_drain", 32'(head()), 32'(model_q[0]));
            cycle(1'b0, 1'b1, 1'b0, '0);
            void'(model_q.pop_front());
        end
        check("wrap_empty", 32'(ir_valid), 0);

        // Asynchronous reset between edges
        cycle(1'b1, 1'b0, 1'b0, 16'hBEEF);
        cycle(1'b1, 1'b0, 1'b0, 16'hCAFE);
        check("pre_arst_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_valid", 32'(ir_valid), 0);
        check("arst_head", 32'(head()), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 16'h4321);
        check("post_arst_head", 32'(head()), 32'h4321);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised instruction register and prefetch queue that replaces the single-entry instruction register between instruction memory and the control unit. It captures up to DEPTH fetched instruction words, presents the oldest one split into four equal-width fields, and releases it when the control unit consumes it. Flush support discards prefetched words on a taken branch or jump, and a sticky overflow flag reports dropped fetches.

## Interface
- IW, 16: instruction word width; must be a multiple of 4.
- DEPTH, 4: queue entries; power of 2, at least 2.
- FW, IW/4: field width (derived; do not override).
- CW, $clog2(DEPTH)+1: occupancy counter width (derived).

- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- instr_data  in  IW  instruction word from memory[pc].
- irwr  in  1  write strobe; push instr_data this cycle.
- ir_rd  in  1  consume strobe; pop the head entry this cycle.
- flush  in  1  synchronous discard of all entries.
- instr_f3  out  FW  head word bits [IW-1 : 3FW].
- instr_f2  out  FW  head word bits [3FW-1 : 2FW].
- instr_f1  out  FW  head word bits [2FW-1 : FW].
- instr_f0  out  FW  head word bits [FW-1 : 0].
- ir_valid  out  1  queue non-empty; the fields are meaningful.
- full  out  1  count == DEPTH.
- count  out  CW  number of occupied entries, 0..DEPTH.
- ovf  out  1  sticky overflow: a push was dropped.

## Operation
- Storage: DEPTH x IW register array with write pointer wp and read pointer rp, each log2(DEPTH) bits. Both pointers wrap naturally from DEPTH-1 to 0.
- Push accepted (push_ok) = irwr & (!full | pop_ok) & !flush. On accept: mem[wp] <= instr_data, wp++.
- Pop accepted (pop_ok) = ir_rd & ir_valid & !flush. On accept: rp++. ir_rd while empty is ignored and has no error effect.
- Simultaneous push and pop:
  - When full: both accepted; count stays at DEPTH. The slot freed by the pop takes the new word.
  - When empty: only the push is accepted. There is no bypass, and count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count next = count + push_ok - pop_ok. full and ir_valid derive combinationally from count.
- Head fields: {instr_f3, f2, f1, f0} = mem[rp] when ir_valid, else all zero. This is a mux from registered state only, with no input-to-output combinational path.
- flush has priority over irwr and ir_rd in the same cycle:
  - wp, rp and count clear to 0; the incoming word is dropped.
  - ovf also clears.
  - Storage contents are not cleared.
- Overflow: irwr & full & !pop_ok & !flush sets ovf. ovf stays high until flush or reset. A dropped push does not alter storage or pointers.

## Timing
- Reset (rst_n low, asynchronous): wp = rp = 0, count = 0, ovf = 0. This gives ir_valid = 0, full = 0, fields = 0.
- Storage array has no reset. Outputs never expose it while count == 0.
- Release of rst_n is synchronous to clk at the edge-sampling level. The first push can be accepted on the first rising edge after deassertion.
- Latency: a word pushed at edge N appears on the fields with ir_valid = 1 after edge N when the queue was empty (1 cycle, registered).
- A pop at edge N exposes the next entry after edge N, or zero fields with ir_valid = 0 if that was the last entry.
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Simulation $display of each accepted push is permitted; it must print time and word as hex.

## Test plan
- Reset then single push: rst_n 0→1; push 16'hA5C3 → next cycle ir_valid = 1, fields = A/5/C/3, count = 1. Pop → ir_valid = 0, fields = 0.
- Fill and overflow (DEPTH = 4): push 1111, 2222, 3333, 4444 → full = 1, count = 4. Push 5555 without pop → ovf = 1, head still 1111. Pop four times → order 1111, 2222, 3333, 4444, no 5555.
- Full push+pop: with queue full of 1111..4444, assert irwr (5555) and ir_rd together → count = 4, head = 2222, ovf = 0. Drain → 2222, 3333, 4444, 5555.
- Empty push+pop and pop-on-empty: empty queue, irwr (7777) with ir_rd → count = 1, head = 7777. ir_rd on empty → no change, ovf = 0.
- Flush priority: 3 entries with ovf set; flush with irwr (9999) and ir_rd → count = 0, ir_valid = 0, ovf = 0. Next push 1234 appears at head.
- Wrap and async reset: run more than 2 x DEPTH push/pop cycles checking FIFO order across pointer wrap. Drop rst_n between edges → count = 0 and ir_valid = 0 immediately, before the next edge.
